// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
//   Shared definitions for the instruction-fetch sequencer: FSM state
//   encoding, PC increment and branch-target alignment mask.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        FETCH    = 3'd1,
        STALL    = 3'd2,
        REDIRECT = 3'd3,
        ERROR    = 3'd4
    } fetch_state_t;

    localparam int unsigned PC_INCR = 4;

    // Wide enough for any practical ADDR_W; callers truncate to their width.
    localparam logic [63:0] ALIGN_MASK = ~64'd3;

    // Width of the imem wait counter; covers MAX_WAIT up to 255.
    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/fetch_sat_counter.sv
// fetch_sat_counter
//   Up-counter that stops at SAT_VAL. Synchronous active-high reset and
//   synchronous clear both return it to zero; clear wins over increment.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high
//   inc   in   count up by one (ignored once SAT_VAL is reached)
//   clr   in   synchronous clear
//   count out  current count
module fetch_sat_counter #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     SAT_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != SAT_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch stage sequencer. Owns the PC, selects PC+4 or a
//   branch target, handshakes with a variable-latency instruction memory,
//   and drives the IF/ID write-enable / flush for stalls and redirects.
//   A fetch that waits MAX_WAIT cycles without imem_ready parks the
//   sequencer in ERROR with a sticky fetch_timeout until reset.
//
//   Optional feature macro: FETCH_PERF_EN adds saturating performance
//   counters (perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt).
//
// State table:
//   BOOT     | one idle cycle after reset, no request
//   FETCH    | request pc from imem, advance on imem_ready
//   STALL    | hazard stall, pc held, no request
//   REDIRECT | bubble after branch, stale imem response ignored
//   ERROR    | imem timeout, sticky, left only via rst
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   branch_taken/_target  redirect request and address (low 2 bits dropped)
//   hazard_stall          load-use stall request
//   imem_ready            imem returns the instruction at pc this cycle
//   pc                    registered fetch address
//   imem_req              fetch request for pc
//   ifid_we, ifid_flush   IF/ID write-enable and clear (combinational)
//   fetch_timeout         sticky imem timeout flag
//   perf_*_cnt            performance counters (FETCH_PERF_EN only)
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MAX_WAIT = 15
`ifdef FETCH_PERF_EN
    ,
    parameter int unsigned       PERF_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              hazard_stall,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              fetch_timeout
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_W-1:0] ALIGN      = ADDR_W'(ALIGN_MASK);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INCR);

    fetch_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              redirect;
    logic              wait_inc;

    // Branch redirect applies in every state except ERROR.
    assign redirect = branch_taken && (state != ERROR);

    assign imem_req   = !rst && (state == FETCH);
    assign ifid_we    = !rst && (state == FETCH) && imem_ready
                        && !hazard_stall && !branch_taken;
    assign ifid_flush = rst || (state == ERROR) || redirect;

    // Only an unanswered, otherwise undisturbed FETCH cycle counts as waiting.
    assign wait_inc = (state == FETCH) && !branch_taken && !hazard_stall && !imem_ready;

    fetch_sat_counter #(
        .WIDTH   (WAIT_W),
        .SAT_VAL ('1)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (wait_inc),
        .clr   (!wait_inc),
        .count (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            fetch_timeout <= 1'b0;
        end else if (redirect) begin
            pc    <= branch_target & ALIGN;
            state <= REDIRECT;
        end else begin
            case (state)
                BOOT:     state <= FETCH;
                REDIRECT: state <= FETCH;
                STALL: begin
                    if (!hazard_stall) state <= FETCH;
                end
                FETCH: begin
                    // A response in a stall cycle is dropped; pc is refetched.
                    if (hazard_stall) begin
                        state <= STALL;
                    end else if (imem_ready) begin
                        pc <= pc + PC_STEP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state         <= ERROR;
                        fetch_timeout <= 1'b1;
                    end
                end
                ERROR:    state <= ERROR;
                default:  state <= ERROR;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    fetch_sat_counter #(.WIDTH(PERF_W), .SAT_VAL('1)) u_perf_fetch (
        .clk (clk), .rst (rst), .inc (ifid_we), .clr (1'b0), .count (perf_fetch_cnt)
    );

    fetch_sat_counter #(.WIDTH(PERF_W), .SAT_VAL('1)) u_perf_stall (
        .clk (clk), .rst (rst), .inc (state == STALL), .clr (1'b0), .count (perf_stall_cnt)
    );

    fetch_sat_counter #(.WIDTH(PERF_W), .SAT_VAL('1)) u_perf_flush (
        .clk (clk), .rst (rst), .inc (ifid_flush), .clr (1'b0), .count (perf_flush_cnt)
    );
`endif

endmodule
